// File: rtl/bram_xfer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bram_xfer_sequencer
// Description : Queues BRAM transfer commands and sequences an address adapter
//               through setup, reload, beat counting and completion reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_xfer_sequencer #(
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16,
    parameter int QDEPTH     = 4
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [ADDR_WIDTH-1:0] cmd_start,
    input  logic [ADDR_WIDTH-1:0] cmd_bound,
    input  logic                  abort,
    input  logic                  s_tvalid,
    input  logic                  s_tready,
    input  logic                  s_tlast,
    input  logic                  m_tvalid,
    input  logic                  m_tready,
    input  logic                  m_tlast,
    output logic                  rw,
    output logic                  addr_reload,
    output logic [ADDR_WIDTH-1:0] bram_start_addr,
    output logic [ADDR_WIDTH-1:0] bram_bound_addr,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  done_beats,
    output logic                  done_aborted,
    output logic                  err
);

    localparam int                  c_PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int                  c_ENTRY_W = 1 + 2 * ADDR_WIDTH;
    localparam logic [c_PTR_W:0]    c_FULL    = (c_PTR_W + 1)'(QDEPTH);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_LOAD  = 3'd2;
    localparam logic [2:0] c_RUN   = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;

    logic [c_ENTRY_W-1:0]  r_mem [QDEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;
    logic                  r_ready_en;

    logic                  r_pop_rw;
    logic [ADDR_WIDTH-1:0] r_pop_start;
    logic [ADDR_WIDTH-1:0] r_pop_bound;

    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_start;
    logic [ADDR_WIDTH-1:0] r_bound;
    logic [CNT_WIDTH-1:0]  r_beats;
    logic [CNT_WIDTH-1:0]  r_done_beats;
    logic                  r_done_aborted;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_bad;
    logic                  w_beat;
    logic                  w_last;
    logic                  w_run_exit;
    logic [CNT_WIDTH-1:0]  w_beats_inc;

    // cmd_ready stays low until the first clock after reset release
    assign cmd_ready   = r_ready_en && (r_count != c_FULL);
    assign w_push      = cmd_valid && cmd_ready;
    // Registered occupancy keeps a fresh push invisible until the next cycle
    assign w_pop       = (r_state == c_IDLE) && (r_count != '0);
    assign w_bad       = r_pop_start > r_pop_bound;

    assign w_beat      = r_rw ? (s_tvalid && s_tready) : (m_tvalid && m_tready);
    assign w_last      = w_beat && (r_rw ? s_tlast : m_tlast);
    assign w_run_exit  = (r_state == c_RUN) && (w_last || abort);
    assign w_beats_inc = (w_beat && (r_beats != c_CNT_MAX)) ? r_beats + 1'b1 : r_beats;

    assign rw              = r_rw;
    assign bram_start_addr = r_start;
    assign bram_bound_addr = r_bound;
    assign done_beats      = r_done_beats;
    assign done_aborted    = r_done_aborted;

    always_ff @(posedge s00_axis_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_rw, cmd_start, cmd_bound};
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_state        <= c_IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_ready_en     <= 1'b0;
            r_pop_rw       <= 1'b1;
            r_pop_start    <= '0;
            r_pop_bound    <= '0;
            r_rw           <= 1'b1;
            r_start        <= '0;
            r_bound        <= '0;
            r_beats        <= '0;
            r_done_beats   <= '0;
            r_done_aborted <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready_en <= 1'b1;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                {r_pop_rw, r_pop_start, r_pop_bound} <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if ((r_state == c_SETUP) && !w_bad) begin
                r_rw    <= r_pop_rw;
                r_start <= r_pop_start;
                r_bound <= r_pop_bound;
            end

            if (r_state == c_LOAD) begin
                r_beats <= '0;
            end else if (r_state == c_RUN) begin
                r_beats <= w_beats_inc;
            end

            // Capture on RUN exit so the results are valid during the DONE cycle
            if (w_run_exit) begin
                r_done_beats   <= w_beats_inc;
                r_done_aborted <= abort && !w_last;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        addr_reload = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        err         = 1'b0;
        case (r_state)
            c_IDLE: begin
                busy = 1'b0;
                if (w_pop) begin
                    w_state_nxt = c_SETUP;
                end
            end
            c_SETUP: begin
                if (w_bad) begin
                    err         = 1'b1;
                    w_state_nxt = c_IDLE;
                end else begin
                    w_state_nxt = c_LOAD;
                end
            end
            c_LOAD: begin
                addr_reload = 1'b1;
                w_state_nxt = c_RUN;
            end
            c_RUN: begin
                if (w_last || abort) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                done        = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_xfer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bram_xfer_sequencer
// Description : Directed self-checking bench for bram_xfer_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_xfer_sequencer;

    localparam int c_AW = 12;
    localparam int c_CW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_rw = 1'b0;
    logic [c_AW-1:0]   cmd_start = '0;
    logic [c_AW-1:0]   cmd_bound = '0;
    logic              abort = 1'b0;
    logic              s_tvalid = 1'b0, s_tready = 1'b0, s_tlast = 1'b0;
    logic              m_tvalid = 1'b0, m_tready = 1'b0, m_tlast = 1'b0;
    logic              rw, addr_reload, busy, done, done_aborted, err;
    logic [c_AW-1:0]   bram_start_addr, bram_bound_addr;
    logic [c_CW-1:0]   done_beats;

    int n_cmp = 0;
    int n_mis = 0;
    int n_reload = 0;
    int n_done = 0;
    int n_err = 0;
    int snap_done, snap_reload, snap_err;

    bram_xfer_sequencer #(.ADDR_WIDTH(c_AW), .CNT_WIDTH(c_CW), .QDEPTH(4)) u_dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_rw           (cmd_rw),
        .cmd_start        (cmd_start),
        .cmd_bound        (cmd_bound),
        .abort            (abort),
        .s_tvalid         (s_tvalid),
        .s_tready         (s_tready),
        .s_tlast          (s_tlast),
        .m_tvalid         (m_tvalid),
        .m_tready         (m_tready),
        .m_tlast          (m_tlast),
        .rw               (rw),
        .addr_reload      (addr_reload),
        .bram_start_addr  (bram_start_addr),
        .bram_bound_addr  (bram_bound_addr),
        .busy             (busy),
        .done             (done),
        .done_beats       (done_beats),
        .done_aborted     (done_aborted),
        .err              (err)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (addr_reload) n_reload++;
        if (done)        n_done++;
        if (err)         n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic rw_i, input logic [c_AW-1:0] st, input logic [c_AW-1:0] bd);
        cmd_valid = 1'b1;
        cmd_rw    = rw_i;
        cmd_start = st;
        cmd_bound = bd;
        check("push_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_reload(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (addr_reload) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    // n beats on the selected stream; optional tlast/abort on the final beat,
    // optional stalls and full activity on the opposite stream
    task automatic beats(input bit wr, input int n, input bit last_fin,
                         input bit abort_fin, input bit noise);
        for (int i = 0; i < n; i++) begin
            if (noise && (i % 7 == 3)) begin
                if (wr) begin s_tvalid = 1; s_tready = 0; s_tlast = 0; end
                else    begin m_tvalid = 1; m_tready = 0; m_tlast = 0; end
                tick();
            end
            if (wr) begin
                s_tvalid = 1; s_tready = 1; s_tlast = last_fin && (i == n - 1);
                {m_tvalid, m_tready, m_tlast} = {3{noise}};
            end else begin
                m_tvalid = 1; m_tready = 1; m_tlast = last_fin && (i == n - 1);
                {s_tvalid, s_tready, s_tlast} = {3{noise}};
            end
            abort = abort_fin && (i == n - 1);
            tick();
        end
        {s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast} = '0;
        abort = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
        check("rst_rw", {31'd0, rw}, 1);
        check("rst_reload", {31'd0, addr_reload}, 0);
        check("rst_start", {20'd0, bram_start_addr}, 0);
        check("rst_bound", {20'd0, bram_bound_addr}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_done_beats", {16'd0, done_beats}, 0);
        check("rst_aborted", {31'd0, done_aborted}, 0);
        check("rst_err", {31'd0, err}, 0);
        rst_n = 1'b1;
        tick();
        check("rel_cmd_ready", {31'd0, cmd_ready}, 1);

        // Write job: 70 beats, tlast on the last
        push(1'b1, 12'd3, 12'd7);
        wait_reload("wr_reload_seen");
        check("wr_rw", {31'd0, rw}, 1);
        check("wr_start", {20'd0, bram_start_addr}, 3);
        check("wr_bound", {20'd0, bram_bound_addr}, 7);
        check("wr_busy", {31'd0, busy}, 1);
        tick();
        check("wr_reload_one_cycle", {31'd0, addr_reload}, 0);
        beats(1'b1, 70, 1'b1, 1'b0, 1'b1);
        check("wr_done", {31'd0, done}, 1);
        check("wr_done_beats", {16'd0, done_beats}, 70);
        check("wr_aborted", {31'd0, done_aborted}, 0);
        tick();
        check("wr_busy_after", {31'd0, busy}, 0);
        check("wr_done_beats_hold", {16'd0, done_beats}, 70);
        check("wr_reload_count", n_reload, 1);
        check("wr_done_count", n_done, 1);

        // Read job: 36 beats, s-stream noise ignored
        push(1'b0, 12'd6, 12'd7);
        wait_reload("rd_reload_seen");
        check("rd_rw", {31'd0, rw}, 0);
        check("rd_start", {20'd0, bram_start_addr}, 6);
        check("rd_bound", {20'd0, bram_bound_addr}, 7);
        tick();
        beats(1'b0, 36, 1'b1, 1'b0, 1'b1);
        check("rd_done", {31'd0, done}, 1);
        check("rd_done_beats", {16'd0, done_beats}, 36);
        check("rd_aborted", {31'd0, done_aborted}, 0);
        tick();

        // Bad command: start > bound
        snap_reload = n_reload;
        snap_err = n_err;
        push(1'b1, 12'd9, 12'd4);
        tick();
        check("bad_err", {31'd0, err}, 1);
        check("bad_busy_setup", {31'd0, busy}, 1);
        tick();
        check("bad_busy_idle", {31'd0, busy}, 0);
        check("bad_err_clear", {31'd0, err}, 0);
        check("bad_rw_kept", {31'd0, rw}, 0);
        check("bad_start_kept", {20'd0, bram_start_addr}, 6);
        check("bad_bound_kept", {20'd0, bram_bound_addr}, 7);
        repeat (3) tick();
        check("bad_no_reload", n_reload, snap_reload);
        check("bad_err_count", n_err, snap_err + 1);

        // Queue full: 5 pushes while a job runs, only 4 accepted
        snap_done = n_done;
        push(1'b1, 12'd16, 12'd20);
        wait_reload("qf_reload_seen");
        tick();
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1;
            cmd_rw    = 1'b1;
            cmd_start = 12'(32 + k);
            cmd_bound = 12'd40;
            check("qf_ready", {31'd0, cmd_ready}, (k < 4) ? 32'd1 : 32'd0);
            tick();
        end
        cmd_valid = 1'b0;
        beats(1'b1, 1, 1'b1, 1'b0, 1'b0);
        check("qf_first_beats", {16'd0, done_beats}, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            wait_reload("qf_job_reload");
            check("qf_job_start", {20'd0, bram_start_addr}, 32'(32 + k));
            tick();
            beats(1'b1, k + 1, 1'b1, 1'b0, 1'b0);
            check("qf_job_beats", {16'd0, done_beats}, 32'(k + 1));
            tick();
        end
        repeat (4) tick();
        check("qf_done_count", n_done, snap_done + 5);
        check("qf_idle", {31'd0, busy}, 0);

        // Abort after 10 beats
        push(1'b1, 12'd0, 12'd2);
        wait_reload("ab_reload_seen");
        tick();
        beats(1'b1, 10, 1'b0, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_done", {31'd0, done}, 1);
        check("ab_done_beats", {16'd0, done_beats}, 10);
        check("ab_aborted", {31'd0, done_aborted}, 1);
        tick();

        // abort held outside RUN must not flush; then abort+tlast together
        abort = 1'b1;
        push(1'b1, 12'd1, 12'd2);
        wait_reload("ab2_reload_seen");
        abort = 1'b0;
        tick();
        beats(1'b1, 1, 1'b1, 1'b1, 1'b0);
        check("ab2_done", {31'd0, done}, 1);
        check("ab2_done_beats", {16'd0, done_beats}, 1);
        check("ab2_aborted", {31'd0, done_aborted}, 0);
        tick();

        // Reset mid-RUN with two queued
        push(1'b0, 12'd5, 12'd9);
        wait_reload("mr_reload_seen");
        tick();
        push(1'b1, 12'd1, 12'd1);
        push(1'b1, 12'd2, 12'd2);
        beats(1'b0, 3, 1'b0, 1'b0, 1'b0);
        snap_done = n_done;
        rst_n = 1'b0;
        #1;
        check("mr_busy", {31'd0, busy}, 0);
        check("mr_rw", {31'd0, rw}, 1);
        check("mr_start", {20'd0, bram_start_addr}, 0);
        check("mr_bound", {20'd0, bram_bound_addr}, 0);
        check("mr_done_beats", {16'd0, done_beats}, 0);
        check("mr_aborted", {31'd0, done_aborted}, 0);
        check("mr_cmd_ready", {31'd0, cmd_ready}, 0);
        check("mr_done", {31'd0, done}, 0);
        repeat (2) tick();
        snap_reload = n_reload;
        rst_n = 1'b1;
        tick();
        check("mr_rel_ready", {31'd0, cmd_ready}, 1);
        repeat (6) tick();
        check("mr_queue_empty", n_reload, snap_reload);
        check("mr_idle", {31'd0, busy}, 0);
        check("mr_no_done", n_done, snap_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
